// File: rtl/gpio_arb_pkg.sv
// Shared definitions for the GPIO register-port arbiter: register map,
// FSM encoding and the access-legality check.
package gpio_arb_pkg;

   localparam logic [9:0] PDOR = 10'd0;
   localparam logic [9:0] PSOR = 10'd1;
   localparam logic [9:0] PCOR = 10'd2;
   localparam logic [9:0] PTOR = 10'd3;
   localparam logic [9:0] PDIR = 10'd4;
   localparam logic [9:0] PDDR = 10'd5;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      RESP  = 2'd2
   } state_t;

   // PDIR is input-only; PDOR and its set/clear/toggle aliases are write-only.
   function automatic logic is_legal(input logic [9:0] addr, input logic we);
      if (we)
         return (addr <= PTOR) || (addr == PDDR);
      else
         return (addr == PDIR) || (addr == PDDR);
   endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin selector: first set request at or after ptr,
// wrapping modulo N.
module rr_picker #(
   parameter int N  = 2,
   parameter int IW = 1
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  onehot,
   output logic [IW-1:0] idx,
   output logic          any
);

   // NOTE: every output gets a default before the loop so no latch is inferred.
   always_comb begin
      onehot = '0;
      idx    = '0;
      any    = 1'b0;
      for (int k = 0; k < N; k++) begin
         int j;
         j = (int'(ptr) + k) % N;
         if (!any && req[j]) begin
            any       = 1'b1;
            onehot[j] = 1'b1;
            idx       = IW'(j);
         end
      end
   end

endmodule

// File: rtl/gpio_bus_arbiter.sv
// Round-robin arbiter sharing one GPIO register port among N requesters.
// Optional bus locking for atomic read-modify-write: define GPIO_ARB_LOCK_EN.
module gpio_bus_arbiter
   import gpio_arb_pkg::*;
#(
   parameter int N     = 2,
   parameter int WIDTH = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [N-1:0]       req,
   input  logic [N-1:0]       req_we,
   input  logic [N*10-1:0]    req_addr,
   input  logic [N*WIDTH-1:0] req_wdata,
   input  logic [N-1:0]       lock,
   output logic [N-1:0]       gnt,
   output logic [N-1:0]       rvalid,
   output logic [WIDTH-1:0]   rdata,
   output logic [9:0]         gpio_address,
   output logic [WIDTH-1:0]   gpio_data,
   output logic               gpio_rden,
   output logic               gpio_wren,
   output logic               gpio_clken,
   input  logic [WIDTH-1:0]   gpio_q
);

   localparam int IW = (N > 1) ? $clog2(N) : 1;

   state_t             state, state_nx;
   logic [IW-1:0]      rr_ptr, w_idx, pick_idx;
   logic [N-1:0]       req_eff, pick_oh, w_oh;
   logic               pick_any;
   logic               we_q;
   logic [9:0]         addr_q;
   logic [WIDTH-1:0]   wdata_q;
   logic               legal;

   assign w_oh  = N'(1) << w_idx;
   assign legal = is_legal(addr_q, we_q);

`ifdef GPIO_ARB_LOCK_EN
   logic          owner_valid;
   logic [IW-1:0] owner;

   // Every grant re-decides ownership; a non-owner is only granted while no owner exists.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         owner_valid <= 1'b0;
         owner       <= '0;
      end else if (state == ISSUE) begin
         owner_valid <= lock[w_idx];
         owner       <= w_idx;
      end else if (state == IDLE && owner_valid && !req[owner] && !lock[owner]) begin
         owner_valid <= 1'b0;
      end
   end

   always_comb begin
      req_eff = req;
      if (owner_valid)
         req_eff = req & (N'(1) << owner);
   end
`else
   logic unused_lock;
   assign unused_lock = ^lock;
   assign req_eff     = req;
`endif

   rr_picker #(.N(N), .IW(IW)) u_picker (
      .req    (req_eff),
      .ptr    (rr_ptr),
      .onehot (pick_oh),
      .idx    (pick_idx),
      .any    (pick_any)
   );

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (pick_any) state_nx = ISSUE;
         ISSUE:   state_nx = we_q ? IDLE : RESP;
         RESP:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      gnt          = '0;
      gpio_address = '0;
      gpio_data    = '0;
      gpio_rden    = 1'b0;
      gpio_wren    = 1'b0;
      gpio_clken   = 1'b0;
      if (state == ISSUE) begin
         gnt          = w_oh;
         gpio_address = addr_q;
         gpio_data    = wdata_q;
         gpio_clken   = legal;
         gpio_rden    = legal && !we_q;
         gpio_wren    = legal && we_q;
      end
   end

   // Reset mid-read drops the pending response: rvalid only rises out of RESP.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_ptr  <= '0;
         w_idx   <= '0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rvalid  <= '0;
         rdata   <= '0;
      end else begin
         rvalid <= '0;
         case (state)
            IDLE: begin
               if (pick_any) begin
                  w_idx   <= pick_idx;
                  we_q    <= req_we[pick_idx];
                  addr_q  <= req_addr[pick_idx*10 +: 10];
                  wdata_q <= req_wdata[pick_idx*WIDTH +: WIDTH];
               end
            end
            ISSUE: rr_ptr <= IW'((int'(w_idx) + 1) % N);
            RESP: begin
               rvalid <= w_oh;
               rdata  <= legal ? gpio_q : '0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_gpio_bus_arbiter.sv
// Directed self-checking bench for gpio_bus_arbiter (N=2, WIDTH=32) with a
// small behavioural GPIO register block on the far side.
module tb_gpio_bus_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  req, req_we, lock;
   logic [19:0] req_addr;
   logic [63:0] req_wdata;
   logic [1:0]  gnt, rvalid;
   logic [31:0] rdata;
   logic [9:0]  gpio_address;
   logic [31:0] gpio_data;
   logic        gpio_rden, gpio_wren, gpio_clken;
   logic [31:0] gpio_q;

   logic [31:0] pdor = '0;
   logic [31:0] pddr = '0;
   logic [31:0] pdir = 32'h0000_003C;

   int n_checks = 0;
   int n_fail   = 0;
   logic [1:0] first_gnt, second_gnt;

   always #5 clk = ~clk;

   gpio_bus_arbiter #(.N(2), .WIDTH(32)) dut (
      .clk          (clk),
      .rst          (rst),
      .req          (req),
      .req_we       (req_we),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .lock         (lock),
      .gnt          (gnt),
      .rvalid       (rvalid),
      .rdata        (rdata),
      .gpio_address (gpio_address),
      .gpio_data    (gpio_data),
      .gpio_rden    (gpio_rden),
      .gpio_wren    (gpio_wren),
      .gpio_clken   (gpio_clken),
      .gpio_q       (gpio_q)
   );

   // GPIO register block model: acts on the edge that ends the ISSUE cycle.
   initial gpio_q = '0;
   always @(posedge clk) begin
      if (gpio_clken && gpio_wren) begin
         case (gpio_address)
            10'd0: pdor <= gpio_data;
            10'd1: pdor <= pdor | gpio_data;
            10'd2: pdor <= pdor & ~gpio_data;
            10'd3: pdor <= pdor ^ gpio_data;
            10'd5: pddr <= gpio_data;
            default: ;
         endcase
      end
      if (gpio_clken && gpio_rden)
         gpio_q <= (gpio_address == 10'd4) ? pdir : pddr;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, " gnt"},     32'(gnt), 32'h0);
      check({tag, " rvalid"},  32'(rvalid), 32'h0);
      check({tag, " rdata"},   rdata, 32'h0);
      check({tag, " address"}, 32'(gpio_address), 32'h0);
      check({tag, " data"},    gpio_data, 32'h0);
      check({tag, " strobes"}, {29'h0, gpio_rden, gpio_wren, gpio_clken}, 32'h0);
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1; req = '0; req_we = '0; lock = '0; req_addr = '0; req_wdata = '0;
      tick(); tick();
      check_idle_outputs("reset");
      rst = 1'b0;

      // 1: write PDOR = 0xA5 from requester 0
      req_we = 2'b01; req_addr[9:0] = 10'd0; req_wdata[31:0] = 32'hA5; req = 2'b01;
      tick();
      check("t1 gnt",      32'(gnt), 32'h1);
      check("t1 address",  32'(gpio_address), 32'h0);
      check("t1 data",     gpio_data, 32'hA5);
      check("t1 strobes",  {29'h0, gpio_rden, gpio_wren, gpio_clken}, 32'h3);
      req = 2'b00;
      tick();
      check("t1 gnt drop", 32'(gnt), 32'h0);
      check("t1 pdor",     pdor, 32'hA5);

      // 2: load PDDR = 0x0F, then requester 1 reads it back
      req_addr[9:0] = 10'd5; req_wdata[31:0] = 32'h0F; req = 2'b01;
      tick();
      check("t2 wr gnt", 32'(gnt), 32'h1);
      req = 2'b00;
      tick();
      req_we = 2'b00; req_addr[19:10] = 10'd5; req = 2'b10;
      tick();
      check("t2 rd gnt",     32'(gnt), 32'h2);
      check("t2 rd strobes", {29'h0, gpio_rden, gpio_wren, gpio_clken}, 32'h5);
      check("t2 rd address", 32'(gpio_address), 32'h5);
      req = 2'b00;
      tick();
      check("t2 rvalid early", 32'(rvalid), 32'h0);
      tick();
      check("t2 rvalid", 32'(rvalid), 32'h2);
      check("t2 rdata",  rdata, 32'h0F);

      // 3: both requesters write continuously; grants alternate with gaps
      req_we = 2'b11;
      req_addr[9:0]  = 10'd1; req_wdata[31:0]  = 32'h100;
      req_addr[19:10] = 10'd2; req_wdata[63:32] = 32'h1;
      req = 2'b11;
      for (int i = 0; i < 8; i++) begin
         tick();
         check($sformatf("t3 gnt cycle %0d", i), 32'(gnt),
               (i % 2 == 1) ? 32'h0 : ((i % 4 == 0) ? 32'h1 : 32'h2));
      end
      req = 2'b00;
      tick();
      check("t3 pdor", pdor, 32'h1A4);

      // 4: illegal read of PCOR, illegal write of PDIR, then a legal PDIR read
      req_we = 2'b00; req_addr[9:0] = 10'd2; req = 2'b01;
      tick();
      check("t4 ill rd gnt",     32'(gnt), 32'h1);
      check("t4 ill rd strobes", {29'h0, gpio_rden, gpio_wren, gpio_clken}, 32'h0);
      req = 2'b00;
      tick(); tick();
      check("t4 ill rd rvalid", 32'(rvalid), 32'h1);
      check("t4 ill rd rdata",  rdata, 32'h0);
      req_we = 2'b10; req_addr[19:10] = 10'd4; req_wdata[63:32] = 32'hFFFF; req = 2'b10;
      tick();
      check("t4 ill wr gnt",     32'(gnt), 32'h2);
      check("t4 ill wr strobes", {29'h0, gpio_rden, gpio_wren, gpio_clken}, 32'h0);
      req = 2'b00;
      tick();
      req_we = 2'b00; req = 2'b10;
      tick();
      check("t4 pdir gnt", 32'(gnt), 32'h2);
      req = 2'b00;
      tick(); tick();
      check("t4 pdir rvalid", 32'(rvalid), 32'h2);
      check("t4 pdir rdata",  rdata, 32'h3C);

      // 5: reset during RESP of a read discards the response and clears rr_ptr
      req_addr[9:0] = 10'd5; req = 2'b01;
      tick();
      check("t5 gnt", 32'(gnt), 32'h1);
      req = 2'b00;
      tick();
      rst = 1'b1;
      #1;
      check_idle_outputs("t5 in reset");
      tick();
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         check($sformatf("t5 no rvalid %0d", i), 32'(rvalid), 32'h0);
      end
      req_we = 2'b11; req_addr[9:0] = 10'd0; req_addr[19:10] = 10'd1;
      req_wdata[31:0] = 32'hA5; req_wdata[63:32] = 32'h0; req = 2'b11;
      tick();
      check("t5 first gnt after reset", 32'(gnt), 32'h1);
      req = 2'b10;
      tick();
      tick();
      check("t5 second gnt", 32'(gnt), 32'h2);
      req = 2'b00;
      tick();

      // 6: requester 0 read-modify-writes PDDR under lock while requester 1 waits
      req_we = 2'b10; req_addr[9:0] = 10'd5; req_addr[19:10] = 10'd1;
      req_wdata[63:32] = 32'h2; lock = 2'b01; req = 2'b11;
      tick();
      check("t6 rd gnt", 32'(gnt), 32'h1);
      req = 2'b10;
      tick();
      tick();
      check("t6 rvalid", 32'(rvalid), 32'h1);
      check("t6 rdata",  rdata, 32'h0F);
      req_we = 2'b11; req_wdata[31:0] = 32'hF0; lock = 2'b00; req = 2'b11;
`ifdef GPIO_ARB_LOCK_EN
      first_gnt = 2'b01; second_gnt = 2'b10;
`else
      first_gnt = 2'b10; second_gnt = 2'b01;
`endif
      tick();
      check("t6 first gnt", 32'(gnt), 32'(first_gnt));
      req = req & ~first_gnt;
      tick();
      check("t6 gap", 32'(gnt), 32'h0);
      tick();
      check("t6 second gnt", 32'(gnt), 32'(second_gnt));
      req = 2'b00;
      tick();
      check("t6 pddr", pddr, 32'hF0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
